// File: rtl/sync_fifo_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_if
//   Bundles the push/pop handshake and status signals of sync_fifo.
//   Clock and reset are kept as plain ports on the FIFO itself.
//
//   Signals
//     read_enable   push request (client -> FIFO)
//     data_in       word to push (client -> FIFO)
//     write_enable  pop request (client -> FIFO)
//     data_out      registered pop result (FIFO -> client)
//     full          count == DEPTH (FIFO -> client)
//     empty         count == 0 (FIFO -> client)
//     count         number of stored words (FIFO -> client)
//
//   Modports
//     master  client side, drives the requests
//     slave   FIFO side, drives the data/status
// ---------------------------------------------------------------------------
interface sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             read_enable;
  logic [WIDTH-1:0] data_in;
  logic             write_enable;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;

  modport master (
    output read_enable,
    output data_in,
    output write_enable,
    input  data_out,
    input  full,
    input  empty,
    input  count
  );

  modport slave (
    input  read_enable,
    input  data_in,
    input  write_enable,
    output data_out,
    output full,
    output empty,
    output count
  );
endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO buffering bytes between the UART and its client.
//   Holds up to DEPTH words of WIDTH bits in arrival order.
//   Naming follows the UART side: read_enable pushes data_in into the FIFO,
//   write_enable pops the oldest word onto data_out.
//   Overflow pushes and underflow pops are silently ignored.
//
//   Ports
//     clock   single clock, all state updates on posedge
//     reset   synchronous, active-high; clears pointers, count, data_out
//     bus     sync_fifo_if slave modport (handshake, data, status)
//
//   All outputs are registered. data_out carries the popped word for exactly
//   one cycle after a successful pop and is 0 on every other cycle.
//   DEPTH may be any value >= 2; pointers wrap explicitly at DEPTH-1.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  sync_fifo_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Pointer advance with explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_p1;
  logic             full_p1;
  logic             empty_p1;
  logic [WIDTH-1:0] data_out_p1;

  logic             pop_ok;
  logic             push_ok;
  logic [CNT_W-1:0] cnt_next;

  // ---- stage 0: request qualification from pre-edge state ----
  // A push into a full FIFO is allowed only when a pop frees a slot on the
  // same edge; the read below sees the old word before the write lands.
  always_comb begin
    pop_ok  = bus.write_enable && !empty_p1;
    push_ok = bus.read_enable && (!full_p1 || pop_ok);

    cnt_next = cnt_p1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_next = cnt_p1 + CNT_ONE;
      2'b01:   cnt_next = cnt_p1 - CNT_ONE;
      default: cnt_next = cnt_p1;
    endcase
  end

  // Storage is never cleared; reset only forgets it through the pointers.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // ---- stage 1: registered pointers, status and pop result ----
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt_p1      <= '0;
      full_p1     <= 1'b0;
      empty_p1    <= 1'b1;
      data_out_p1 <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr      <= ptr_inc(rd_ptr);
        data_out_p1 <= mem[rd_ptr];
      end else begin
        data_out_p1 <= '0;
      end
      cnt_p1   <= cnt_next;
      full_p1  <= (cnt_next == CNT_FULL);
      empty_p1 <= (cnt_next == '0);
    end
  end

  assign bus.data_out = data_out_p1;
  assign bus.count    = cnt_p1;
  assign bus.full     = full_p1;
  assign bus.empty    = empty_p1;

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//   Self-checking bench for sync_fifo (WIDTH=8, DEPTH=4).
//   Inputs are driven on the negedge; outputs are sampled 1 time unit after
//   the posedge. A directed vector table, a few hand-written corner-case
//   sequences and a randomized run checked against a queue-based model.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit       rst;
    bit       re;
    bit [7:0] din;
    bit       we;
    int       exp_do;
    int       exp_full;
    int       exp_empty;
    int       exp_count;
  } vec_t;

  vec_t vecs[$];

  int passed = 0;
  int total  = 0;

  // Reference model: ordered queue of stored words plus expected data_out.
  logic [7:0] model_q[$];
  int         model_do = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock: drive on negedge, update model at posedge, settle #1 after.
  task automatic step(input bit r, input bit re, input bit [7:0] d, input bit we);
    bit pop_ok;
    bit push_ok;
    @(negedge clock);
    reset            = r;
    bus.read_enable  = re;
    bus.data_in      = d;
    bus.write_enable = we;
    @(posedge clock);
    if (r) begin
      model_q.delete();
      model_do = 0;
    end else begin
      pop_ok  = we && (model_q.size() > 0);
      push_ok = re && ((model_q.size() < DEPTH) || pop_ok);
      model_do = 0;
      if (pop_ok) model_do = int'(model_q.pop_front());
      if (push_ok) model_q.push_back(d);
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data_out"}, int'(bus.data_out), model_do);
    chk({tag, ".count"},    int'(bus.count),    model_q.size());
    chk({tag, ".full"},     int'(bus.full),     int'(model_q.size() == DEPTH));
    chk({tag, ".empty"},    int'(bus.empty),    int'(model_q.size() == 0));
  endtask

  task automatic chk_outs(input string tag, input int d, input int f, input int e, input int c);
    chk({tag, ".data_out"}, int'(bus.data_out), d);
    chk({tag, ".full"},     int'(bus.full),     f);
    chk({tag, ".empty"},    int'(bus.empty),    e);
    chk({tag, ".count"},    int'(bus.count),    c);
  endtask

  initial begin
    reset            = 1'b1;
    bus.read_enable  = 1'b0;
    bus.data_in      = '0;
    bus.write_enable = 1'b0;

    // Directed table: reset, fill past full, idle while full, drain past empty.
    vecs.push_back('{1, 0, 8'd0, 0, 0, 0, 1, 0});
    for (int k = 1; k <= 16; k++)
      vecs.push_back('{0, 1, 8'(k), 0, 0, int'(k >= 4), 0, (k < 4) ? k : 4});
    for (int k = 0; k < 16; k++)
      vecs.push_back('{0, 0, 8'd0, 0, 0, 1, 0, 4});
    for (int p = 1; p <= 20; p++)
      vecs.push_back('{0, 0, 8'd0, 1, (p <= 4) ? p : 0, 0, int'(p >= 4), (p < 4) ? 4 - p : 0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].re, vecs[i].din, vecs[i].we);
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_do, vecs[i].exp_full,
               vecs[i].exp_empty, vecs[i].exp_count);
    end

    // Full FIFO: push 9 and pop together, then drain across the wrap point.
    step(1, 0, 8'd0, 0);
    for (int k = 1; k <= 4; k++) step(0, 1, 8'(k), 0);
    chk_outs("fill4", 0, 1, 0, 4);
    step(0, 1, 8'd9, 1);
    chk_outs("full_push_pop", 1, 1, 0, 4);
    step(0, 0, 8'd0, 1); chk_outs("drain1", 2, 0, 0, 3);
    step(0, 0, 8'd0, 1); chk_outs("drain2", 3, 0, 0, 2);
    step(0, 0, 8'd0, 1); chk_outs("drain3", 4, 0, 0, 1);
    step(0, 0, 8'd0, 1); chk_outs("drain_wrap", 9, 0, 1, 0);
    step(0, 0, 8'd0, 1); chk_outs("underflow", 0, 0, 1, 0);

    // Push and pop together while empty: push stored, nothing popped.
    step(0, 1, 8'd77, 1);
    chk_outs("empty_push_pop", 0, 0, 0, 1);
    step(0, 0, 8'd0, 1);
    chk_outs("empty_push_pop_drain", 77, 0, 1, 0);

    // Reset with a simultaneous push discards everything.
    step(0, 1, 8'd10, 0);
    step(0, 1, 8'd11, 0);
    chk_outs("pre_reset", 0, 0, 0, 2);
    step(1, 1, 8'd12, 0);
    chk_outs("reset_with_push", 0, 0, 1, 0);
    step(0, 0, 8'd0, 1);
    chk_outs("pop_after_reset", 0, 0, 1, 0);

    // Randomized run against the queue model, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      bit r;
      bit re;
      bit we;
      r  = ($urandom_range(0, 99) == 0);
      re = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 65 : 35));
      we = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 35 : 65));
      step(r, re, 8'($urandom_range(1, 255)), we);
      chk_model("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
